// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU status stage: flag bundle, skid-buffer
// state encoding and ALU operation codes.
package alu_pkg;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

endpackage

// File: rtl/alu_flags_gen.sv
// Combinational N/Z/C/V derivation from an ALU result and its operands.
// V is only computed when ALU_STATUS_OVERFLOW_EN is defined; otherwise it is 0.
module alu_flags_gen
    import alu_pkg::*;
#(
    parameter int bits = 32
) (
    input  logic [bits-1:0] a_i,
    input  logic [bits-1:0] b_i,
    input  logic [bits-1:0] y_i,
    input  logic            y_cb_i,
    input  logic            s_i,
    output logic            n_o,
    output logic            z_o,
    output logic            c_o,
    output logic            v_o
);

    assign n_o = y_i[bits-1];
    assign z_o = (y_i == '0);
    assign c_o = y_cb_i;

`ifdef ALU_STATUS_OVERFLOW_EN
    // Signed overflow: result sign disagrees with A when the effective operand
    // signs agree (B is negated for subtract, hence the inverted comparison).
    always_comb begin
        v_o = 1'b0;
        if (s_i == ALU_OP_SUB) begin
            v_o = (a_i[bits-1] != b_i[bits-1]) && (y_i[bits-1] != a_i[bits-1]);
        end else if (s_i == ALU_OP_ADD) begin
            v_o = (a_i[bits-1] == b_i[bits-1]) && (y_i[bits-1] != a_i[bits-1]);
        end
    end
`else
    logic unused_ops;
    assign unused_ops = ^{a_i, b_i, s_i};
    assign v_o        = 1'b0;
`endif

endmodule

// File: rtl/alu_status_stage.sv
// Registered ALU status stage: flags derived at push time, 2-entry FIFO skid
// buffer toward the consumer, saturating carry/borrow counter.
// Optional overflow flag enabled by defining ALU_STATUS_OVERFLOW_EN.
module alu_status_stage
    import alu_pkg::*;
#(
    parameter int bits  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [bits-1:0]  A,
    input  logic [bits-1:0]  B,
    input  logic             S,
    input  logic [bits-1:0]  Y,
    input  logic             Y_CB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [bits-1:0]  R,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cb_count
);

    typedef struct packed {
        logic [bits-1:0] r;
        alu_flags_t      f;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    buf_state_t       state_q;
    entry_t           head_q;
    entry_t           tail_q;
    entry_t           in_entry;
    logic [CNT_W-1:0] cb_count_q;
    logic [CNT_W-1:0] cb_count_d;
    logic             push;
    logic             pop;

    alu_flags_gen #(.bits(bits)) u_flags (
        .a_i    (A),
        .b_i    (B),
        .y_i    (Y),
        .y_cb_i (Y_CB),
        .s_i    (S),
        .n_o    (in_entry.f.n),
        .z_o    (in_entry.f.z),
        .c_o    (in_entry.f.c),
        .v_o    (in_entry.f.v)
    );
    assign in_entry.r = Y;

    assign in_ready  = (state_q != BUF_FULL);
    assign out_valid = (state_q != BUF_EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // The head register always feeds the outputs; the tail only holds the
    // second entry while FULL and shifts forward on the pop that leaves FULL.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (push) begin
                        head_q  <= in_entry;
                        state_q <= BUF_ONE;
                    end
                end
                BUF_ONE: begin
                    if (push && pop) begin
                        head_q <= in_entry;
                    end else if (push) begin
                        tail_q  <= in_entry;
                        state_q <= BUF_FULL;
                    end else if (pop) begin
                        state_q <= BUF_EMPTY;
                    end
                end
                BUF_FULL: begin
                    if (pop) begin
                        head_q  <= tail_q;
                        state_q <= BUF_ONE;
                    end
                end
                default: state_q <= BUF_EMPTY;
            endcase
        end
    end

    always_comb begin
        cb_count_d = cb_count_q;
        if (cnt_clr) begin
            cb_count_d = '0;
        end else if (push && in_entry.f.c && (cb_count_q != CNT_MAX)) begin
            cb_count_d = cb_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cb_count_q <= '0;
        end else begin
            cb_count_q <= cb_count_d;
        end
    end

    assign R        = head_q.r;
    assign N        = head_q.f.n;
    assign Z        = head_q.f.z;
    assign C        = head_q.f.c;
    assign V        = head_q.f.v;
    assign cb_count = cb_count_q;

endmodule

// File: tb/tb_alu_status_stage.sv
// Bench for alu_status_stage: directed scenarios with literal expectations, then
// randomized traffic against a queue-based reference model.
module tb_alu_status_stage;

    localparam int W  = 32;
    localparam int CW = 4;

`ifdef ALU_STATUS_OVERFLOW_EN
    localparam logic V_EXP = 1'b1;
`else
    localparam logic V_EXP = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] r;
        logic n;
        logic z;
        logic c;
        logic v;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          S;
    logic [W-1:0]  Y;
    logic          Y_CB;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  R;
    logic          N;
    logic          Z;
    logic          C;
    logic          V;
    logic          cnt_clr;
    logic [CW-1:0] cb_count;

    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    int   model_cnt = 0;
    bit   last_push = 0;
    bit   started   = 0;

    always #5 clk = ~clk;

    alu_status_stage #(.bits(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .S         (S),
        .Y         (Y),
        .Y_CB      (Y_CB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .R         (R),
        .N         (N),
        .Z         (Z),
        .C         (C),
        .V         (V),
        .cnt_clr   (cnt_clr),
        .cb_count  (cb_count)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected entry from arithmetic meaning: V is "true result not representable
    // in W signed bits", independent of any bit-level rule.
    function automatic exp_t ref_entry(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic s, input logic [W-1:0] y, input logic cb);
        exp_t   e;
        longint sa;
        longint sb;
        longint res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        res = s ? (sa - sb) : (sa + sb);
        e.r = y;
        e.n = ($signed(y) < 0);
        e.z = (y == '0);
        e.c = cb;
`ifdef ALU_STATUS_OVERFLOW_EN
        e.v = (res != longint'($signed(res[W-1:0])));
`else
        e.v = (res == 64'sd0) && 1'b0;
`endif
        return e;
    endfunction

    task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        A = a;
        B = b;
        S = s;
        if (!s) begin
            {Y_CB, Y} = {1'b0, a} + {1'b0, b};
        end else begin
            Y    = a - b;
            Y_CB = (a < b);
        end
        in_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 8)
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Reference model: FIFO of expected entries plus an integer counter.
    always @(posedge clk) begin : model
        bit   push;
        bit   pop;
        exp_t e;
        if (rst) begin
            q.delete();
            model_cnt = 0;
            last_push = 0;
            started   = 1;
        end else begin
            push = in_valid && (q.size() < 2);
            pop  = out_ready && (q.size() > 0);
            e    = ref_entry(A, B, S, Y, Y_CB);
            if (cnt_clr) model_cnt = 0;
            else if (push && e.c && model_cnt < (1 << CW) - 1) model_cnt++;
            if (pop) void'(q.pop_front());
            if (push) q.push_back(e);
            last_push = push;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_in_ready", in_ready, q.size() < 2);
            chk("m_out_valid", out_valid, q.size() > 0);
            if (q.size() > 0) chk("m_head", {R, N, Z, C, V}, q[0]);
            chk("m_cb_count", cb_count, model_cnt);
        end
    end

    initial begin
        rst = 1; in_valid = 0; A = 0; B = 0; S = 0; Y = 0; Y_CB = 0;
        out_ready = 0; cnt_clr = 0;
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_R", R, 0);
        chk("rst_flags", {N, Z, C, V}, 0);
        chk("rst_cb", cb_count, 0);
        rst = 0;
        out_ready = 1;

        drive_op(32'hFFFF_FFFF, 32'h1, 1'b0);
        step(); in_valid = 0;
        $display("add FFFFFFFF+1: R=%h NZCV=%b%b%b%b cb=%0d", R, N, Z, C, V, cb_count);
        chk("add_carry_valid", out_valid, 1);
        chk("add_carry_R", R, 0);
        chk("add_carry_NZCV", {N, Z, C, V}, 4'b0110);
        chk("add_carry_cb", cb_count, 1);

        drive_op(32'h7FFF_FFFF, 32'h1, 1'b0);
        step(); in_valid = 0;
        $display("add 7FFFFFFF+1: R=%h NZCV=%b%b%b%b", R, N, Z, C, V);
        chk("add_ovf_R", R, 32'h8000_0000);
        chk("add_ovf_NZCV", {N, Z, C, V}, {3'b100, V_EXP});

        drive_op(32'h3, 32'h5, 1'b1);
        step(); in_valid = 0;
        $display("sub 3-5: R=%h NZCV=%b%b%b%b cb=%0d", R, N, Z, C, V, cb_count);
        chk("sub_R", R, 32'hFFFF_FFFE);
        chk("sub_NZCV", {N, Z, C, V}, 4'b1010);
        chk("sub_cb", cb_count, 2);
        step();
        chk("drain_valid", out_valid, 0);

        out_ready = 0;
        drive_op(0, 1, 1'b0); step();
        drive_op(0, 2, 1'b0); step();
        drive_op(0, 3, 1'b0);
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_head1", R, 1);
        step();
        chk("bp_stall_R", R, 1);
        chk("bp_stall_in_ready", in_ready, 0);
        out_ready = 1;
        step();
        chk("bp_head2", R, 2);
        step(); in_valid = 0;
        chk("bp_head3", R, 3);
        step();
        chk("bp_empty", out_valid, 0);
        $display("backpressure sequence done");

        cnt_clr = 1; step(); cnt_clr = 0;
        chk("clr_cb", cb_count, 0);
        repeat (17) begin
            drive_op(32'hFFFF_FFFF, 32'h1, 1'b0);
            step();
        end
        $display("17 carry pushes: cb=%0d", cb_count);
        chk("sat_cb", cb_count, 15);
        cnt_clr = 1; step(); cnt_clr = 0; in_valid = 0;
        chk("clr_wins_cb", cb_count, 0);
        step();

        out_ready = 0;
        drive_op(32'hFFFF_FFFF, 32'h2, 1'b0); step();
        drive_op(32'hFFFF_FFFF, 32'h3, 1'b0); step();
        chk("pre_rst_in_ready", in_ready, 0);
        chk("pre_rst_cb", cb_count, 2);
        drive_op(32'hFFFF_FFFF, 32'h4, 1'b0);
        rst = 1; step(); rst = 0;
        $display("mid reset: out_valid=%b in_ready=%b cb=%0d", out_valid, in_ready, cb_count);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_cb", cb_count, 0);
        step(); in_valid = 0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_R", R, 3);
        chk("post_rst_cb", cb_count, 1);

        repeat (4000) begin
            @(posedge clk);
            #1;
            if (!in_valid || last_push) begin
                if ($urandom % 10 < 7) drive_op(pick(), pick(), 1'($urandom % 2));
                else in_valid = 0;
            end
            out_ready = ($urandom % 10) < 6;
            cnt_clr   = ($urandom % 40) == 0;
            rst       = ($urandom % 300) == 0;
        end
        rst = 0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_status_stage.md
# alu_status_stage

Registered output stage directly downstream of the ALU arithmetic unit. Captures the add/sub result and carry/borrow, derives N/Z/C/V status flags, and presents them to the consumer through a 2-entry valid/ready skid buffer. It also keeps a saturating count of carry/borrow events.

## Interface
- `bits`, default 32: data width; must match the ALU arithmetic unit.
- `CNT_W`, default 16: width of the carry/borrow event counter.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: the ALU result and its operands are valid this cycle.
- `in_ready`  out  1: the stage can accept an entry.
- `A`, `B`  in  bits: operands that produced `Y`; used for the overflow flag.
- `S`  in  1: ALU operation, 0 = add, 1 = subtract.
- `Y`  in  bits: ALU result.
- `Y_CB`  in  1: ALU carry (add) or borrow (subtract).
- `out_valid`  out  1: `R` and the flags are valid.
- `out_ready`  in  1: the consumer accepts the entry.
- `R`  out  bits: registered result.
- `N`, `Z`, `C`, `V`  out  1 each: registered flags.
- `cnt_clr`  in  1: synchronous clear of `cb_count`.
- `cb_count`  out  CNT_W: saturating count of accepted entries with C=1.

## Operation
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`.
- Flags are computed from the input at push time:
  - N = `Y[bits-1]`.
  - Z = (`Y` == 0).
  - C = `Y_CB`, passed through unchanged. For subtract, 1 means unsigned A < B.
  - V for add (S=0): `A[msb]==B[msb] && Y[msb]!=A[msb]`.
  - V for subtract (S=1): `A[msb]!=B[msb] && Y[msb]!=A[msb]`.
- The buffer has 2 entries and is strictly FIFO. Its state machine is EMPTY, ONE, FULL:
  - EMPTY -> ONE on push.
  - ONE -> FULL on push without pop.
  - ONE -> EMPTY on pop without push.
  - ONE -> ONE on simultaneous push and pop.
  - FULL -> ONE on pop. There is no push while FULL.
- `in_ready` = (state != FULL). It is combinational from state only and never depends on `out_ready`.
- The head entry drives `R`/`N`/`Z`/`C`/`V`. These outputs hold stable while `out_valid && !out_ready`.
- `cb_count`:
  - Increments by 1 on a push whose C=1.
  - Saturates at 2^CNT_W-1.
  - `cnt_clr` wins over a same-cycle increment, giving 0.
  - Counter operation is independent of the buffer state.

## Timing
- Reset (`rst` high at a `clk` edge):
  - State goes to EMPTY.
  - `out_valid`=0, `R`=0, `N`=`Z`=`C`=`V`=0.
  - `cb_count`=0, `in_ready`=1 from the next cycle.
- While `rst` is high, push and pop are ignored.
- Reset mid-operation discards all buffered entries; no partial output is produced.
- Latency is 1 cycle: a push at edge k gives `out_valid`=1 after edge k when the buffer was EMPTY.
- Throughput is 1 entry/cycle with `out_ready` held high.
- A push into FULL is impossible because `in_ready`=0. The upstream must hold its `Y`/`A`/`B`/`S`/`Y_CB` until accepted.
- A pop from EMPTY is a no-op.

## Configuration
- `ALU_STATUS_OVERFLOW_EN`:
  - Defined: V is computed as above.
  - Undefined: V is tied to 0, and `A`/`B` are unused except bit positions that feed nothing; lint waivers are permitted.
- N, Z, C and the counter are unaffected by the macro.

## Structure
- Package `alu_pkg`:
  - typedef `alu_flags_t` (packed struct: n, z, c, v).
  - typedef for the buffer-state enum (EMPTY, ONE, FULL).
  - localparams `ALU_OP_ADD`=1'b0 and `ALU_OP_SUB`=1'b1.
- Sub-module `alu_flags_gen`: combinational flag derivation from `A`, `B`, `Y`, `Y_CB`, `S`. Instantiated once, at the stage input.
- Entry storage: two registers of {`R`, `alu_flags_t`} plus the state register. No memories.

## Test plan
All scenarios use bits=32 unless stated.
- Add, A=0xFFFFFFFF, B=1, S=0, Y=0, Y_CB=1 -> next cycle R=0, Z=1, C=1, N=0, V=0; `cb_count`=1.
- Add, A=0x7FFFFFFF, B=1, Y=0x80000000, Y_CB=0 -> N=1, V=1, C=0, Z=0. With the macro undefined, V=0.
- Subtract, A=3, B=5, S=1, Y=0xFFFFFFFE, Y_CB=1 -> N=1, C=1, V=0, Z=0.
- Backpressure:
  - Hold `out_ready`=0 and offer 3 consecutive entries -> first two accepted, `in_ready`=0 on the third.
  - Raise `out_ready` -> outputs in order 1, 2, 3.
  - Outputs stay stable while stalled.
- Counter saturation, CNT_W=4:
  - 17 pushes with C=1 -> `cb_count`=15.
  - `cnt_clr` in the same cycle as a C=1 push -> `cb_count`=0.
- Reset mid-operation: buffer FULL, assert `rst` for 1 cycle -> `out_valid`=0, `in_ready`=1, `cb_count`=0. A new push afterward emerges with 1-cycle latency.
